atm_keypad_frontend: RTL
========================

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, inactivity cycles in any entry state before abort.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port card_in  in  1  level, card present.
REQ-005 SHALL have port key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-006 SHALL have port key_code  in  4  0-9 digit, 4'hA ENTER, 4'hB CANCEL, 4'hC CLEAR; others ignored.
REQ-007 SHALL have port req_ready  in  1  ATM core accepts request.
REQ-008 SHALL have port resp_valid  in  1  one-cycle strobe qualifying resp_state/resp_balance.
REQ-009 SHALL have port resp_state  in  3  ATM state code for the completed request.
REQ-010 SHALL have port resp_balance  in  16  account balance after the request.
REQ-011 SHALL have ports acc_num out 4, pin out 16 (4 BCD digits, first digit in [15:12]), amount out 16 (binary), operation out 3; stable while req_valid.
REQ-012 SHALL have port req_valid  out  1  request pending.
REQ-013 SHALL have ports disp_balance out 16, busy out 1, error out 1 (sticky until next card), timeout out 1 (one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE, GET_ACC, GET_PIN, GET_OP, GET_AMT, ISSUE, WAIT_RESP.
REQ-015 IDLE -> GET_ACC on card_in high; clears acc_num, pin, amount, operation, error.
REQ-016 GET_ACC: digit loads acc_num; digit > 9 impossible; ENTER with acc_num entered -> GET_PIN; ENTER with no digit ignored.
REQ-017 GET_PIN: each digit shifts into pin LSB nibble, max 4 digits, 5th+ digit ignored; ENTER after exactly 4 digits -> GET_OP; ENTER with <4 digits sets error, clears pin, stays.
REQ-018 GET_OP: digit 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 EXIT load operation; BALANCE/EXIT -> ISSUE; WITHDRAW/DEPOSIT -> GET_AMT; other digits ignored.
REQ-019 GET_AMT: amount <= amount*10 + digit; result > 16'hFFFF saturates at 16'hFFFF and sets error; ENTER -> ISSUE (amount 0 permitted).
REQ-020 CLEAR zeroes the field of the current entry state and its digit count; CANCEL in any entry state -> IDLE.
REQ-021 ISSUE asserts req_valid; transfer occurs on the cycle req_valid and req_ready are both high; next state WAIT_RESP; req_valid deasserts the following cycle.
REQ-022 WAIT_RESP: on resp_valid, disp_balance <= resp_balance; operation EXIT -> IDLE, else -> GET_OP with operation cleared and amount zeroed.
REQ-023 resp_valid in any state other than WAIT_RESP SHALL be ignored.
REQ-024 Inactivity counter resets on every key_valid and state change; reaching TIMEOUT_CYCLES in GET_* states -> IDLE with timeout pulse; not counted in ISSUE/WAIT_RESP.
REQ-025 card_in falling in any state except ISSUE/WAIT_RESP -> IDLE next cycle; during ISSUE/WAIT_RESP, the transaction completes, then -> IDLE.
REQ-026 key_valid and card_in fall in the same cycle: card removal wins, key discarded.
REQ-027 busy SHALL be high in ISSUE and WAIT_RESP only.

Reset
REQ-028 rst SHALL force IDLE immediately, all outputs 0, counters 0, regardless of state, including mid-handshake.
REQ-029 After rst deasserts, a card already present SHALL start GET_ACC on the next rising edge.

Structure
REQ-030 State codes, operation codes (BALANCE=1, WITHDRAW=2, DEPOSIT=3, EXIT=4) and key codes SHALL live in the shared definitions.v.
REQ-031 Decimal accumulation with saturation SHALL be sub-module bcd_accumulator (amount_in, digit -> amount_out, overflow), combinational.
REQ-032 FSM and data registers SHALL stay in atm_keypad_frontend; no other sub-modules.

Verification
REQ-033 card_in=1, keys 3,ENTER,1,2,3,4,ENTER,2,1,5,0,ENTER, req_ready=1 -> acc_num=3, pin=16'h1234, operation=2, amount=150, one-cycle req_valid.
REQ-034 Amount keys 9,9,9,9,9,9 -> amount=16'hFFFF, error=1.
REQ-035 PIN keys 1,2,ENTER -> error=1, pin=0, state GET_PIN; then 5,6,7,8,ENTER -> GET_OP.
REQ-036 No key for TIMEOUT_CYCLES=20 in GET_PIN -> timeout pulses once in cycle 20, state IDLE, outputs cleared.
REQ-037 req_ready held low 5 cycles in ISSUE -> req_valid stays high, fields stable; resp_valid with resp_balance=16'd650 -> disp_balance=650, return to GET_OP.
REQ-038 rst pulse during WAIT_RESP -> req_valid=0, busy=0, state IDLE asynchronously; late resp_valid ignored.

Source files
------------

// File: rtl/atm_keypad_frontend_pkg.sv
// Shared definitions for the ATM keypad front end.
//   state_t       : front-end FSM state codes (also used on the debug port)
//   OP_*          : operation codes carried on the request bus
//   KEY_*         : keypad codes for the non-digit keys
//   is_digit()    : true for keypad codes 0-9
//   is_entry()    : true for the GET_* data-entry states
package atm_keypad_frontend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ACC   = 3'd1,
    ST_GET_PIN   = 3'd2,
    ST_GET_OP    = 3'd3,
    ST_GET_AMT   = 3'd4,
    ST_ISSUE     = 3'd5,
    ST_WAIT_RESP = 3'd6
  } state_t;

  localparam logic [2:0] OP_NONE     = 3'd0;
  localparam logic [2:0] OP_BALANCE  = 3'd1;
  localparam logic [2:0] OP_WITHDRAW = 3'd2;
  localparam logic [2:0] OP_DEPOSIT  = 3'd3;
  localparam logic [2:0] OP_EXIT     = 3'd4;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CANCEL = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  localparam logic [2:0] PIN_DIGITS = 3'd4;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_entry(input state_t s);
    return (s == ST_GET_ACC) || (s == ST_GET_PIN) ||
           (s == ST_GET_OP)  || (s == ST_GET_AMT);
  endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Request/response bus between the keypad front end and the ATM core.
//   master : front end  -- drives req_valid, acc_num, pin, amount, operation
//   slave  : ATM core   -- drives req_ready, resp_valid, resp_state, resp_balance
// Handshake: a request is transferred on every rising clock edge where
// req_valid and req_ready are both high; while req_valid is high without
// req_ready, req_valid and all request fields hold steady. resp_valid is a
// one-cycle strobe with no back-pressure that qualifies resp_state and
// resp_balance.
interface atm_keypad_frontend_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] amount;
  logic [2:0]  operation;
  logic        resp_valid;
  logic [2:0]  resp_state;
  logic [15:0] resp_balance;

  modport master (
    output req_valid, acc_num, pin, amount, operation,
    input  req_ready, resp_valid, resp_state, resp_balance
  );

  modport slave (
    input  req_valid, acc_num, pin, amount, operation,
    output req_ready, resp_valid, resp_state, resp_balance
  );
endinterface

// File: rtl/atm_keypad_frontend_bcd_accumulator.sv
// Combinational decimal accumulator with saturation.
//   amount_in  : current binary value
//   digit      : decimal digit 0-9 to append
//   amount_out : amount_in*10 + digit, clamped to 16'hFFFF
//   overflow   : high when the exact result does not fit in 16 bits
module bcd_accumulator (
  input  logic [15:0] amount_in,
  input  logic [3:0]  digit,
  output logic [15:0] amount_out,
  output logic        overflow
);

  // 65535*10 + 9 needs 20 bits, so the exact result never wraps here.
  logic [19:0] exact;

  always_comb begin
    exact      = ({4'd0, amount_in} * 20'd10) + {16'd0, digit};
    overflow   = (exact > 20'h0FFFF);
    amount_out = overflow ? 16'hFFFF : exact[15:0];
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects account number, PIN, operation and amount
// from a keypad, issues one request to the ATM core and shows the returned
// balance.
//   clk, rst        : clock, asynchronous active-high reset
//   card_in         : card present (level)
//   key_valid/code  : one-cycle key strobe and code (0-9, A=ENTER, B=CANCEL, C=CLEAR)
//   bus             : request/response bus (master side)
//   disp_balance    : last balance reported by the core
//   busy            : request outstanding (ISSUE / WAIT_RESP)
//   error           : sticky entry error, cleared when a new card session starts
//   timeout         : one-cycle pulse on an inactivity abort
//   state_dbg       : current FSM state
module atm_keypad_frontend
  import atm_keypad_frontend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          card_in,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  atm_keypad_frontend_if.master         bus,
  output logic [15:0]                   disp_balance,
  output logic                          busy,
  output logic                          error,
  output logic                          timeout,
  output state_t                        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [3:0]       acc_num_q;
  logic [15:0]      pin_q;
  logic [15:0]      amount_q;
  logic [2:0]       operation_q;
  logic             req_valid_q;
  logic [2:0]       digit_cnt;
  logic [CNT_W-1:0] idle_cnt;
  // Card pulled while a request is in flight: finish the transaction, then idle.
  logic             card_gone;

  logic        key_digit;
  logic        key_enter;
  logic        key_cancel;
  logic        key_clear;
  logic        expired;
  logic        abort;
  logic [15:0] acc_out;
  logic        acc_ovf;

  bcd_accumulator u_bcd_accumulator (
    .amount_in  (amount_q),
    .digit      (key_code),
    .amount_out (acc_out),
    .overflow   (acc_ovf)
  );

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);

  // A key in the same cycle restarts the inactivity window, so it beats expiry.
  assign expired = (idle_cnt == CNT_LAST) && !key_valid;
  // Card removal has priority over any key in the same cycle.
  assign abort   = !card_in || key_cancel || expired;

  assign bus.req_valid = req_valid_q;
  assign bus.acc_num   = acc_num_q;
  assign bus.pin       = pin_q;
  assign bus.amount    = amount_q;
  assign bus.operation = operation_q;
  assign state_dbg     = state;

  logic unused_resp_state;
  assign unused_resp_state = ^bus.resp_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      acc_num_q    <= '0;
      pin_q        <= '0;
      amount_q     <= '0;
      operation_q  <= OP_NONE;
      req_valid_q  <= 1'b0;
      digit_cnt    <= '0;
      idle_cnt     <= '0;
      card_gone    <= 1'b0;
      disp_balance <= '0;
      busy         <= 1'b0;
      error        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt  <= '0;
          digit_cnt <= '0;
          card_gone <= 1'b0;
          if (card_in) begin
            state       <= ST_GET_ACC;
            acc_num_q   <= '0;
            pin_q       <= '0;
            amount_q    <= '0;
            operation_q <= OP_NONE;
            error       <= 1'b0;
          end
        end

        ST_GET_ACC, ST_GET_PIN, ST_GET_OP, ST_GET_AMT: begin
          // Every GET_* transition is caused by a key, so clearing on key
          // also covers the clear-on-state-change rule.
          idle_cnt <= key_valid ? '0 : idle_cnt + 1'b1;
          if (abort) begin
            state       <= ST_IDLE;
            acc_num_q   <= '0;
            pin_q       <= '0;
            amount_q    <= '0;
            operation_q <= OP_NONE;
            digit_cnt   <= '0;
            idle_cnt    <= '0;
            timeout     <= card_in && expired;
          end else if (key_clear) begin
            digit_cnt <= '0;
            case (state)
              ST_GET_ACC: acc_num_q   <= '0;
              ST_GET_PIN: pin_q       <= '0;
              ST_GET_OP:  operation_q <= OP_NONE;
              default:    amount_q    <= '0;
            endcase
          end else begin
            case (state)
              ST_GET_ACC: begin
                if (key_digit) begin
                  acc_num_q <= key_code;
                  digit_cnt <= 3'd1;
                end else if (key_enter && (digit_cnt != 3'd0)) begin
                  state     <= ST_GET_PIN;
                  digit_cnt <= '0;
                end
              end

              ST_GET_PIN: begin
                if (key_digit && (digit_cnt < PIN_DIGITS)) begin
                  pin_q     <= {pin_q[11:0], key_code};
                  digit_cnt <= digit_cnt + 3'd1;
                end else if (key_enter) begin
                  digit_cnt <= '0;
                  if (digit_cnt == PIN_DIGITS) begin
                    state <= ST_GET_OP;
                  end else begin
                    error <= 1'b1;
                    pin_q <= '0;
                  end
                end
              end

              ST_GET_OP: begin
                if (key_digit) begin
                  case (key_code)
                    4'd1, 4'd4: begin
                      operation_q <= key_code[2:0];
                      state       <= ST_ISSUE;
                      req_valid_q <= 1'b1;
                      busy        <= 1'b1;
                    end
                    4'd2, 4'd3: begin
                      operation_q <= key_code[2:0];
                      state       <= ST_GET_AMT;
                      amount_q    <= '0;
                      digit_cnt   <= '0;
                    end
                    default: ;
                  endcase
                end
              end

              ST_GET_AMT: begin
                if (key_digit) begin
                  amount_q <= acc_out;
                  if (acc_ovf) error <= 1'b1;
                  if (digit_cnt != 3'd7) digit_cnt <= digit_cnt + 3'd1;
                end else if (key_enter) begin
                  state       <= ST_ISSUE;
                  req_valid_q <= 1'b1;
                  busy        <= 1'b1;
                  digit_cnt   <= '0;
                end
              end

              default: ;
            endcase
          end
        end

        ST_ISSUE: begin
          idle_cnt <= '0;
          if (!card_in) card_gone <= 1'b1;
          if (req_valid_q && bus.req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT_RESP;
          end
        end

        ST_WAIT_RESP: begin
          idle_cnt <= '0;
          if (!card_in) card_gone <= 1'b1;
          if (bus.resp_valid) begin
            disp_balance <= bus.resp_balance;
            busy         <= 1'b0;
            card_gone    <= 1'b0;
            amount_q     <= '0;
            operation_q  <= OP_NONE;
            if ((operation_q == OP_EXIT) || card_gone || !card_in) begin
              state     <= ST_IDLE;
              acc_num_q <= '0;
              pin_q     <= '0;
            end else begin
              state <= ST_GET_OP;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
